// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam int         NUM_DIGITS  = 4;
  localparam logic [3:0] AN_OFF      = 4'b1111;
  localparam logic [3:0] BRIGHT_FULL = 4'd15;

  // Everything latched together at a frame boundary.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic                       lz_en;
    logic [3:0]                 bright;
  } snap_t;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display-side bundle: scan request inputs and the anode/decoder drive outputs.
interface sseg_scan_ctrl_if;
  logic       en;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic       lz_en;
  logic [3:0] brightness;
  logic [3:0] an;
  logic [3:0] digit;
  logic       seg_blank;
  logic       frame_start;

  modport master (
    output en, digit1, digit2, digit3, digit4, lz_en, brightness,
    input  an, digit, seg_blank, frame_start
  );

  modport slave (
    input  en, digit1, digit2, digit3, digit4, lz_en, brightness,
    output an, digit, seg_blank, frame_start
  );
endinterface

// File: rtl/sseg_lz_mask.sv
// Leading-zero suppression mask; a digit is hidden only if it and every digit to its left is zero.
module sseg_lz_mask
  import sseg_pkg::*;
(
  input  logic [NUM_DIGITS-1:0][3:0] dig,
  input  logic                       lz_en,
  output logic [NUM_DIGITS-1:0]      supp
);

  // The rightmost digit always shows, so an all-zero value reads "0".
  assign supp[3] = lz_en & (dig[3] == 4'd0);
  assign supp[2] = supp[3] & (dig[2] == 4'd0);
  assign supp[1] = supp[2] & (dig[1] == 4'd0);
  assign supp[0] = 1'b0;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scanner: per-slot dead time, frame-coherent snapshot,
// leading-zero suppression and PWM brightness, all outputs registered.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int SLOT_CYCLES = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           reset,
  sseg_scan_ctrl_if.slave bus
);

  localparam int               CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  slot_q, slot_d;
  logic [3:0]        pwm_q, pwm_d;
  snap_t             snap_q, snap_in;
  logic              snap_take;
  logic [NUM_DIGITS-1:0] supp;
  logic              pwm_on;
  logic              an_act;
  logic [3:0]        an_d;
  logic [3:0]        digit_d;

  assign snap_in = {bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.lz_en, bus.brightness};

  sseg_lz_mask u_lz_mask (
    .dig   (snap_q.dig),
    .lz_en (snap_q.lz_en),
    .supp  (supp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    pwm_d     = pwm_q;
    snap_take = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      slot_d  = '0;
      pwm_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_BLANK;
          idx_d     = 2'd0;
          slot_d    = '0;
          pwm_d     = 4'd0;
          snap_take = 1'b1;
        end
        S_BLANK: begin
          slot_d = slot_q + 1'b1;
          pwm_d  = pwm_q + 4'd1;
          if (slot_q == DEAD_LAST) state_d = S_DRIVE;
        end
        S_DRIVE: begin
          pwm_d = pwm_q + 4'd1;
          if (slot_q == SLOT_LAST) begin
            state_d   = S_BLANK;
            slot_d    = '0;
            idx_d     = idx_q + 2'd1;
            snap_take = (idx_q == 2'd3);
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output stage: gated by en so dropping en darkens the display on the very next edge.
  assign pwm_on  = (snap_q.bright == BRIGHT_FULL) | (pwm_q < snap_q.bright);
  assign an_act  = bus.en & (state_q == S_DRIVE) & ~supp[idx_q] & pwm_on;
  assign an_d    = an_act ? ~(4'b0001 << idx_q) : AN_OFF;
  assign digit_d = (!bus.en || state_q == S_IDLE) ? 4'd0 : snap_q.dig[idx_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      slot_q  <= '0;
      pwm_q   <= 4'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      pwm_q   <= pwm_d;
      if (snap_take) snap_q <= snap_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.an          <= AN_OFF;
      bus.digit       <= 4'd0;
      bus.seg_blank   <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.an          <= an_d;
      bus.digit       <= digit_d;
      bus.seg_blank   <= ~an_act;
      bus.frame_start <= snap_take;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: frame-position reference model feeding a per-cycle scoreboard.
module tb_sseg_scan_ctrl;
  localparam int SLOT  = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] digit;
    logic       blank;
    logic       fs;
  } exp_t;

  localparam exp_t DARK = '{an: 4'hF, digit: 4'h0, blank: 1'b1, fs: 1'b0};

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  exp_t sb_q[$];
  int   bq[$];
  logic [15:0] cur_d = '0, old_d = '0;
  logic        cur_lz = 1'b0, old_lz = 1'b0;
  logic [15:0] pats [2] = '{16'h0050, 16'h0000};
  int          want [2][4] = '{'{12, 12, 0, 0}, '{12, 0, 0, 0}};
  int          brs  [3] = '{4, 0, 15};

  sseg_scan_ctrl_if bus ();
  sseg_scan_ctrl_if bus2 ();

  sseg_scan_ctrl #(.SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  sseg_scan_ctrl #(.SLOT_CYCLES(34), .DEAD_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  // Expected outputs k cycles after the frame_start edge, from the frame position.
  function automatic exp_t model(int kk, logic [15:0] d, logic lz);
    exp_t e;
    int pos, idx, s;
    logic [3:0] sup;
    e.fs = (kk % FRAME == 0);
    e.an = 4'hF;
    e.blank = 1'b1;
    e.digit = 4'd0;
    if (kk > 0) begin
      pos = (kk - 1) % FRAME;
      idx = pos / SLOT;
      s   = pos % SLOT;
      sup[0] = 1'b0;
      sup[3] = lz && (d[15:12] == 4'd0);
      sup[2] = sup[3] && (d[11:8] == 4'd0);
      sup[1] = sup[2] && (d[7:4] == 4'd0);
      e.digit = d[idx*4 +: 4];
      if (s >= DEAD && !sup[idx]) begin
        e.an[idx] = 1'b0;
        e.blank = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic exp_t sample();
    return {bus.an, bus.digit, bus.seg_blank, bus.frame_start};
  endfunction

  task automatic push_cycle();
    if (k % FRAME == 0) begin
      old_d  = cur_d;
      old_lz = cur_lz;
      cur_d  = {bus.digit4, bus.digit3, bus.digit2, bus.digit1};
      cur_lz = bus.lz_en;
      sb_q.push_back(model(k, old_d, old_lz));
    end else begin
      sb_q.push_back(model(k, cur_d, cur_lz));
    end
    k++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (sample() !== DARK) begin
        errors++;
        $display("FAIL reset_hold got %b want %b", sample(), DARK);
      end
    end
    reset = 1'b1;
    k = 0;
  endtask

  task automatic test_scan();
    exp_t e, g;
    repeat (66) begin
      push_cycle();
      e = sb_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scan k=%0d got an=%b digit=%h blank=%b fs=%b want an=%b digit=%h blank=%b fs=%b",
                 k - 1, g.an, g.digit, g.blank, g.fs, e.an, e.digit, e.blank, e.fs);
      end
    end
  endtask

  task automatic test_snapshot();
    exp_t e, g;
    int n;
    n = 0;
    while (k % FRAME != 12 || n < 64) begin
      if (k % FRAME == 12 && n == 0) bus.digit1 = 4'd9;
      if (bus.digit1 == 4'd9) n++;
      push_cycle();
      e = sb_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL snapshot k=%0d got an=%b digit=%h blank=%b fs=%b want an=%b digit=%h blank=%b fs=%b",
                 k - 1, g.an, g.digit, g.blank, g.fs, e.an, e.digit, e.blank, e.fs);
      end
    end
  endtask

  task automatic test_lz();
    exp_t e, g;
    int lo [4];
    for (int c = 0; c < 2; c++) begin
      while (k % FRAME != 0) begin
        push_cycle();
        e = sb_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL lz_align k=%0d got %b want %b", k - 1, g, e);
        end
      end
      bus.lz_en = 1'b1;
      {bus.digit4, bus.digit3, bus.digit2, bus.digit1} = pats[c];
      lo = '{0, 0, 0, 0};
      for (int j = 0; j <= 64; j++) begin
        push_cycle();
        e = sb_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL lz k=%0d got an=%b digit=%h blank=%b want an=%b digit=%h blank=%b",
                   k - 1, g.an, g.digit, g.blank, e.an, e.digit, e.blank);
        end
        if (j >= 1)
          for (int i = 0; i < 4; i++) if (bus.an[i] == 1'b0) lo[i]++;
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lo[i] !== want[c][i]) begin
          errors++;
          $display("FAIL lz_count pat=%h an[%0d] low=%0d want %0d", pats[c], i, lo[i], want[c][i]);
        end
      end
    end
  endtask

  task automatic test_enable();
    exp_t e, g;
    bus.lz_en = 1'b0;
    {bus.digit4, bus.digit3, bus.digit2, bus.digit1} = 16'h1234;
    while (k % FRAME != 0) begin
      push_cycle();
      e = sb_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin errors++; $display("FAIL en_align k=%0d got %b want %b", k - 1, g, e); end
    end
    repeat (6) begin
      push_cycle();
      e = sb_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin errors++; $display("FAIL en_pre k=%0d got %b want %b", k - 1, g, e); end
    end
    checks++;
    if (bus.an !== 4'b1110) begin errors++; $display("FAIL en_middrive an=%b want 1110", bus.an); end
    bus.en = 1'b0;
    repeat (3) begin
      sb_q.push_back(DARK);
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin errors++; $display("FAIL en_off got %b want %b", g, e); end
    end
    bus.en = 1'b1;
    k = 0;
    repeat (34) begin
      push_cycle();
      e = sb_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL en_restart k=%0d got an=%b digit=%h blank=%b fs=%b want an=%b digit=%h blank=%b fs=%b",
                 k - 1, g.an, g.digit, g.blank, g.fs, e.an, e.digit, e.blank, e.fs);
      end
    end
  endtask

  task automatic test_brightness();
    int lows, unbl, w_exp;
    for (int b = 0; b < 3; b++) begin
      bus2.brightness = brs[b][3:0];
      bus2.en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus2.frame_start !== 1'b1) begin
        errors++;
        $display("FAIL bright_fs br=%0d frame_start=%b want 1", brs[b], bus2.frame_start);
      end
      for (int w = 0; w < 4; w++) begin
        bq.push_back((brs[b] == 15) ? 32 : 2 * brs[b]);
        lows = 0;
        unbl = 0;
        repeat (34) begin
          @(posedge clk);
          @(negedge clk);
          if (bus2.an != 4'hF) lows++;
          if (bus2.seg_blank == 1'b0) unbl++;
        end
        w_exp = bq.pop_front();
        checks++;
        if (lows !== w_exp) begin
          errors++;
          $display("FAIL bright_an br=%0d slot=%0d low=%0d want %0d", brs[b], w, lows, w_exp);
        end
        checks++;
        if (unbl !== w_exp) begin
          errors++;
          $display("FAIL bright_blank br=%0d slot=%0d unblanked=%0d want %0d", brs[b], w, unbl, w_exp);
        end
      end
      bus2.en = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    exp_t e, g;
    bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b1;
    k = 0;
    repeat (33) begin
      push_cycle();
      e = sb_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin errors++; $display("FAIL ar_pre k=%0d got %b want %b", k - 1, g, e); end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (sample() !== DARK) begin
      errors++;
      $display("FAIL async_reset got %b want %b", sample(), DARK);
    end
    @(negedge clk);
    checks++;
    if (sample() !== DARK) begin
      errors++;
      $display("FAIL async_reset_hold got %b want %b", sample(), DARK);
    end
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.en = 1'b1;
    {bus.digit4, bus.digit3, bus.digit2, bus.digit1} = 16'h1234;
    bus.lz_en = 1'b0;
    bus.brightness = 4'd15;
    bus2.en = 1'b0;
    {bus2.digit4, bus2.digit3, bus2.digit2, bus2.digit1} = 16'h1234;
    bus2.lz_en = 1'b0;
    bus2.brightness = 4'd15;
    test_reset();
    test_scan();
    test_snapshot();
    test_lz();
    test_enable();
    test_brightness();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Scan controller for the 4-digit seven-segment display. It time-multiplexes four BCD digits onto the shared anode/segment datapath. It replaces the separate refresh counter, anode control and digit mux with one sequenced block, adding inter-digit dead time (anti-ghosting), frame-coherent digit snapshots, leading-zero suppression and PWM brightness. It drives the BCD decoder (digit) and the board anodes (an).

Parameters:
SLOT_CYCLES, 100000, clk cycles per digit slot (1 ms at 100 MHz; 250 Hz frame); must be > DEAD_CYCLES
DEAD_CYCLES, 1000, blanking cycles at the start of each slot; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
en  input  1  scan enable; 0 forces display dark and FSM to IDLE
digit1  input  4  BCD, rightmost digit (an[0])
digit2  input  4  BCD, an[1]
digit3  input  4  BCD, an[2]
digit4  input  4  BCD, leftmost digit (an[3])
lz_en  input  1  leading-zero suppression enable
brightness  input  4  0 = off, 1..14 = n/16 duty, 15 = 100%
an  output  4  active-low anode enables, at most one low
digit  output  4  BCD value to the decoder
seg_blank  output  1  1 = decoder forces all segments off
frame_start  output  1  one-cycle pulse at each frame start (idx 0 snapshot)

Behaviour:
- Reset (reset=0, asynchronous): an=4'b1111, digit=0, seg_blank=1, frame_start=0; FSM=IDLE, idx=0, slot_cnt=0, pwm_cnt=0, snapshot registers=0.
- All outputs are registered. They show internal state from the previous cycle, so they lag by exactly 1 cycle.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE -> BLANK when en=1. Entry sets slot_cnt=0 and idx=0, takes a snapshot and pulses frame_start.
  - BLANK -> DRIVE on the cycle slot_cnt==DEAD_CYCLES-1.
  - DRIVE -> BLANK on the cycle slot_cnt==SLOT_CYCLES-1. slot_cnt wraps to 0 and idx increments mod 4.
  - On the idx 3->0 wrap: snapshot and frame_start pulse.
  - en=0 has priority in any state: next state IDLE, counters cleared.
- slot_cnt: width clog2(SLOT_CYCLES). Increments every cycle in BLANK/DRIVE and holds 0 in IDLE.
- Snapshot: digit1..4, lz_en and brightness are captured together. Input changes mid-frame are invisible until the next frame_start.
- digit output = snapshot digit[idx] in both BLANK and DRIVE (presented during dead time so the decoder settles); 0 in IDLE.
- Leading-zero mask, from snapshot, only when lz_en=1:
  - digit4 suppressed if digit4==0.
  - digit3 suppressed if digit4==0 and digit3==0.
  - digit2 suppressed if digit4, digit3 and digit2 are all 0.
  - digit1 is never suppressed (0000 displays "0").
- pwm_cnt: 4-bit, free-running in BLANK/DRIVE, cleared in IDLE. pwm_on = (bright==15) | (pwm_cnt < bright).
- an[idx]=0 only when state==DRIVE, idx not suppressed and pwm_on. Otherwise an=4'b1111.
- seg_blank = ~(anode active), so it is 1 whenever an==4'b1111.
- No overlap: dead time guarantees at least DEAD_CYCLES cycles with an=1111 between any two different anodes.
- Non-BCD digit values (10-15) pass through unchanged; the decoder handles them.

Decomposition:
- Shared package sseg_pkg:
  - state encoding localparams (S_IDLE, S_BLANK, S_DRIVE)
  - NUM_DIGITS=4
  - AN_OFF=4'b1111
  - BRIGHT_FULL=4'd15
- One natural combinational sub-module: sseg_lz_mask. Inputs: snapshot digits and lz_en. Output: 4-bit suppress mask.

Test Plan (SLOT_CYCLES=8, DEAD_CYCLES=2 unless noted):
1. Hold reset=0, then toggle clk -> an=1111, digit=0, seg_blank=1, frame_start=0 throughout. Then release with en=1, digits 4/3/2/1 = 1/2/3/4, lz_en=0, brightness=15:
   - frame_start pulses once.
   - digit=4 with an=1111 for 2 cycles, then an=1110 for 6 cycles.
   - Then digit=3: 2 cycles dark, an=1101 for 6 cycles; and so on.
   - frame_start period = 32 cycles.
2. Change digit1 from 4 to 9 during the idx1 slot -> digit stays 4 in the remaining idx0 slots of the current frame; 9 appears only after the next frame_start.
3. lz_en=1, digits 4..1 = 0,0,5,0 -> an[3] and an[2] never low, an[1]/an[0] driven. With digits=0000 -> only an[0] ever low, digit=0.
4. SLOT_CYCLES=34, DEAD_CYCLES=2:
   - brightness=4 -> exactly 8 an-low cycles per drive window.
   - brightness=0 -> an stays 1111, seg_blank stays 1.
   - brightness=15 -> 32 low cycles per window.
5. Drop en to 0 mid-DRIVE -> an=1111, seg_blank=1, digit=0 one cycle later. Re-assert en -> frame_start pulse and scan restarts at idx0 with a full dead time.
6. Assert reset=0 mid-DRIVE between clock edges -> an=1111, seg_blank=1, frame_start=0 immediately, without waiting for a clk edge.
